// File: rtl/ps2_keycode_rx.sv
// PS/2 Set-2 keyboard receiver: synchronizes the pins, deframes 11-bit frames and
// translates the supported scancodes into a held 8-bit HID usage code.
module ps2_keycode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_event,
    output logic       frame_error
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Synchronizers reset to 1 (the idle line level) so reset release never fakes an edge
    logic [STAGES-1:0] clk_sync_reg;
    logic [STAGES-1:0] data_sync_reg;
    logic              clk_prev_reg;
    logic              sync_clk;
    logic              sync_data;
    logic              fall_edge;

    always_ff @(posedge clock) begin
        if (reset) begin
            clk_sync_reg  <= {STAGES{1'b1}};
            data_sync_reg <= {STAGES{1'b1}};
            clk_prev_reg  <= 1'b1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[STAGES-2:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[STAGES-2:0], ps2_data};
            clk_prev_reg  <= clk_sync_reg[STAGES-1];
        end
    end

    assign sync_clk  = clk_sync_reg[STAGES-1];
    assign sync_data = data_sync_reg[STAGES-1];
    assign fall_edge = clk_prev_reg & ~sync_clk;

    state_t          state_reg, state_next;
    logic [2:0]      bitcnt_reg, bitcnt_next;
    logic [7:0]      shift_reg, shift_next;
    logic            parity_reg, parity_next;
    logic [TW-1:0]   timeout_reg, timeout_next;
    logic            brk_pend_reg, brk_pend_next;
    logic            ext_pend_reg, ext_pend_next;
    logic [7:0]      keycode_reg, keycode_next;
    logic            key_event_reg, key_event_next;
    logic            frame_error_reg, frame_error_next;

    logic [7:0]      hid_code;
    logic            hid_valid;
    logic            frame_good;

    // Translation keyed on the extended prefix so that a bare 75 stays unmapped
    always_comb begin
        hid_code  = 8'h00;
        hid_valid = 1'b1;
        case ({ext_pend_reg, shift_reg})
            9'h029:  hid_code = 8'h2C;
            9'h05A:  hid_code = 8'h28;
            9'h01D:  hid_code = 8'h1A;
            9'h01C:  hid_code = 8'h04;
            9'h01B:  hid_code = 8'h16;
            9'h023:  hid_code = 8'h07;
            9'h076:  hid_code = 8'h29;
            9'h175:  hid_code = 8'h52;
            9'h172:  hid_code = 8'h51;
            9'h16B:  hid_code = 8'h50;
            9'h174:  hid_code = 8'h4F;
            default: hid_valid = 1'b0;
        endcase
    end

    assign frame_good = sync_data & (^{shift_reg, parity_reg});

    always_comb begin
        state_next       = state_reg;
        bitcnt_next      = bitcnt_reg;
        shift_next       = shift_reg;
        parity_next      = parity_reg;
        timeout_next     = timeout_reg;
        brk_pend_next    = brk_pend_reg;
        ext_pend_next    = ext_pend_reg;
        keycode_next     = keycode_reg;
        frame_error_next = 1'b0;
        key_event_next   = 1'b0;

        if (state_reg == IDLE || fall_edge) begin
            timeout_next = '0;
        end else begin
            timeout_next = timeout_reg + TW'(1);
        end

        case (state_reg)
            IDLE: begin
                if (fall_edge) begin
                    if (!sync_data) begin
                        state_next  = DATA;
                        bitcnt_next = 3'd0;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall_edge) begin
                    shift_next  = {sync_data, shift_reg[7:1]};
                    bitcnt_next = bitcnt_reg + 3'd1;
                    if (bitcnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall_edge) begin
                    parity_next = sync_data;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall_edge) begin
                    state_next  = IDLE;
                    bitcnt_next = 3'd0;
                    if (!frame_good) begin
                        frame_error_next = 1'b1;
                        brk_pend_next    = 1'b0;
                        ext_pend_next    = 1'b0;
                    end else if (shift_reg == 8'hE0) begin
                        ext_pend_next = 1'b1;
                    end else if (shift_reg == 8'hF0) begin
                        brk_pend_next = 1'b1;
                    end else begin
                        if (hid_valid) begin
                            if (!brk_pend_reg) begin
                                keycode_next = hid_code;
                            end else if (hid_code == keycode_reg) begin
                                keycode_next = 8'h00;
                            end
                        end
                        brk_pend_next = 1'b0;
                        ext_pend_next = 1'b0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A stalled keyboard clock mid-frame abandons the frame and any pending prefix
        if (state_reg != IDLE && !fall_edge && timeout_reg == TIMEOUT_LAST) begin
            state_next       = IDLE;
            bitcnt_next      = 3'd0;
            timeout_next     = '0;
            frame_error_next = 1'b1;
            brk_pend_next    = 1'b0;
            ext_pend_next    = 1'b0;
        end

        key_event_next = (keycode_next != keycode_reg);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            bitcnt_reg      <= 3'd0;
            shift_reg       <= 8'h00;
            parity_reg      <= 1'b0;
            timeout_reg     <= '0;
            brk_pend_reg    <= 1'b0;
            ext_pend_reg    <= 1'b0;
            keycode_reg     <= 8'h00;
            key_event_reg   <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bitcnt_reg      <= bitcnt_next;
            shift_reg       <= shift_next;
            parity_reg      <= parity_next;
            timeout_reg     <= timeout_next;
            brk_pend_reg    <= brk_pend_next;
            ext_pend_reg    <= ext_pend_next;
            keycode_reg     <= keycode_next;
            key_event_reg   <= key_event_next;
            frame_error_reg <= frame_error_next;
        end
    end

    assign keycode     = keycode_reg;
    assign key_event   = key_event_reg;
    assign frame_error = frame_error_reg;

endmodule
